// File: rtl/vic_pkg.sv
// ---------------------------------------------------------------------------
// vic_pkg : shared constants, FSM encoding and ISR helpers for the VIC.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vic_pkg;

  localparam int N_SRC  = 31;
  localparam int AW     = 5;
  localparam int PRIO_W = 3;
  localparam int N_LVL  = 1 << PRIO_W;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  // Index of the highest in-service level, 0 when nothing is in service.
  function automatic logic [PRIO_W-1:0] isr_top(input logic [N_LVL-1:1] v);
    isr_top = '0;
    for (int l = 1; l < N_LVL; l++) begin
      if (v[l]) isr_top = PRIO_W'(l);
    end
  endfunction

  function automatic logic [N_LVL-1:1] isr_clr_top(input logic [N_LVL-1:1] v);
    logic [PRIO_W-1:0] t;
    t = isr_top(v);
    isr_clr_top = v;
    for (int l = 1; l < N_LVL; l++) begin
      if (t == PRIO_W'(l)) isr_clr_top[l] = 1'b0;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/vic_prio_sel.sv
// ---------------------------------------------------------------------------
// vic_prio_sel : picks the highest-priority pending source above the running
// priority; ties resolve to the lowest index.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vic_prio_sel
  import vic_pkg::*;
(
  input  logic [N_SRC-1:0]        i_pend,
  input  logic [N_SRC*PRIO_W-1:0] i_prio,
  input  logic [PRIO_W-1:0]       i_run_prio,
  output logic                    o_valid,
  output logic [AW-1:0]           o_vec,
  output logic [PRIO_W-1:0]       o_prio
);

  logic              w_valid;
  logic [AW-1:0]     w_vec;
  logic [PRIO_W-1:0] w_prio;

  // Strict '>' on the running best keeps the earliest (lowest) index on ties.
  always_comb begin
    w_valid = 1'b0;
    w_vec   = '0;
    w_prio  = '0;
    for (int s = 0; s < N_SRC; s++) begin
      if (i_pend[s] && (i_prio[s*PRIO_W +: PRIO_W] > i_run_prio) &&
          (i_prio[s*PRIO_W +: PRIO_W] > w_prio)) begin
        w_valid = 1'b1;
        w_vec   = AW'(s);
        w_prio  = i_prio[s*PRIO_W +: PRIO_W];
      end
    end
  end

  assign o_valid = w_valid;
  assign o_vec   = w_vec;
  assign o_prio  = w_prio;

endmodule

`default_nettype wire

// File: rtl/vic_nest_ctrl.sv
// ---------------------------------------------------------------------------
// vic_nest_ctrl : VIC priority scheduler and nesting controller.
// Define VIC_NEST_EN for multi-level preemption; otherwise single busy level.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vic_nest_ctrl
  import vic_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic [N_SRC-1:0]        i_pend,
  input  logic [N_SRC*PRIO_W-1:0] i_prio,
  input  logic                    i_ack,
  input  logic                    i_eoi,
  output logic                    o_IRQ,
  output logic [AW-1:0]           o_irq_addr,
  output logic [PRIO_W-1:0]       o_run_prio
);

  state_t            r_state;
  logic [N_SRC-1:0]  r_pend;
  logic [N_SRC-1:0]  w_pend_clr;
  logic [PRIO_W-1:0] r_prio;
  logic              w_ack_fire;
  logic [PRIO_W-1:0] w_thresh;
  logic [PRIO_W-1:0] w_run_next;
  logic              w_cand_valid;
  logic [AW-1:0]     w_cand_vec;
  logic [PRIO_W-1:0] w_cand_prio;

  assign w_ack_fire = (r_state == ST_REQ) && i_ack;

  always_comb begin
    w_pend_clr = '0;
    for (int s = 0; s < N_SRC; s++) begin
      w_pend_clr[s] = w_ack_fire && (o_irq_addr == AW'(s));
    end
  end

`ifdef VIC_NEST_EN
  logic [N_LVL-1:1] r_isr;
  logic [N_LVL-1:1] w_isr_next;

  // EOI retires the top level before the ack inserts the new one.
  always_comb begin
    w_isr_next = r_isr;
    if (i_eoi) w_isr_next = isr_clr_top(r_isr);
    for (int l = 1; l < N_LVL; l++) begin
      if (w_ack_fire && (r_prio == PRIO_W'(l))) w_isr_next[l] = 1'b1;
    end
    w_run_next = isr_top(w_isr_next);
  end

  assign w_thresh = o_run_prio;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_isr <= '0;
    else          r_isr <= w_isr_next;
  end
`else
  logic              r_busy;
  logic [PRIO_W-1:0] r_busy_prio;
  logic              w_busy_next;
  logic [PRIO_W-1:0] w_busy_prio_next;

  always_comb begin
    w_busy_next      = r_busy & ~i_eoi;
    w_busy_prio_next = w_busy_next ? r_busy_prio : '0;
    if (w_ack_fire) begin
      w_busy_next      = 1'b1;
      w_busy_prio_next = r_prio;
    end
    w_run_next = w_busy_prio_next;
  end

  // An all-ones threshold blocks every candidate while busy: no preemption.
  assign w_thresh = r_busy ? '1 : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy      <= 1'b0;
      r_busy_prio <= '0;
    end else begin
      r_busy      <= w_busy_next;
      r_busy_prio <= w_busy_prio_next;
    end
  end
`endif

  vic_prio_sel u_prio_sel (
    .i_pend     (r_pend),
    .i_prio     (i_prio),
    .i_run_prio (w_thresh),
    .o_valid    (w_cand_valid),
    .o_vec      (w_cand_vec),
    .o_prio     (w_cand_prio)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_pend     <= '0;
      r_prio     <= '0;
      o_IRQ      <= 1'b0;
      o_irq_addr <= '0;
      o_run_prio <= '0;
    end else begin
      r_pend     <= (r_pend & ~w_pend_clr) | i_pend;
      o_run_prio <= w_run_next;
      case (r_state)
        ST_IDLE: begin
          if (i_en && w_cand_valid) begin
            r_state    <= ST_REQ;
            r_prio     <= w_cand_prio;
            o_IRQ      <= 1'b1;
            o_irq_addr <= w_cand_vec;
          end
        end
        ST_REQ: begin
          if (i_ack || !i_en) begin
            r_state <= ST_IDLE;
            o_IRQ   <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          o_IRQ   <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vic_nest_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vic_nest_ctrl : directed self-checking bench for vic_nest_ctrl.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vic_nest_ctrl;
  import vic_pkg::*;

  logic                    i_clk;
  logic                    i_rst_n;
  logic                    i_en;
  logic [N_SRC-1:0]        i_pend;
  logic [N_SRC*PRIO_W-1:0] i_prio;
  logic                    i_ack;
  logic                    i_eoi;
  logic                    o_IRQ;
  logic [AW-1:0]           o_irq_addr;
  logic [PRIO_W-1:0]       o_run_prio;

  int n_checks = 0;
  int n_errors = 0;

  vic_nest_ctrl dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (i_en),
    .i_pend     (i_pend),
    .i_prio     (i_prio),
    .i_ack      (i_ack),
    .i_eoi      (i_eoi),
    .o_IRQ      (o_IRQ),
    .o_irq_addr (o_irq_addr),
    .o_run_prio (o_run_prio)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_prio(input int s, input logic [PRIO_W-1:0] p);
    i_prio[s*PRIO_W +: PRIO_W] = p;
  endtask

  task automatic pulse_pend(input logic [N_SRC-1:0] m);
    i_pend = m;
    tick();
    i_pend = '0;
  endtask

  task automatic do_ack();
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
  endtask

  task automatic do_eoi();
    i_eoi = 1'b1;
    tick();
    i_eoi = 1'b0;
  endtask

  // Checks the presented request, acks it, then retires it with EOI.
  task automatic serve(input string tag, input int vec, input int prio, input int after);
    chk({tag, "_irq"}, 32'(o_IRQ), 32'd1);
    chk({tag, "_addr"}, 32'(o_irq_addr), 32'(vec));
    do_ack();
    chk({tag, "_irq_low"}, 32'(o_IRQ), 32'd0);
    chk({tag, "_run"}, 32'(o_run_prio), 32'(prio));
    do_eoi();
    chk({tag, "_run_eoi"}, 32'(o_run_prio), 32'(after));
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_en    = 1'b0;
    i_pend  = '0;
    i_prio  = '0;
    i_ack   = 1'b0;
    i_eoi   = 1'b0;
    #17;
    chk("rst_irq", 32'(o_IRQ), 32'd0);
    chk("rst_addr", 32'(o_irq_addr), 32'd0);
    chk("rst_run", 32'(o_run_prio), 32'd0);
    tick();
    i_rst_n = 1'b1;
    i_en    = 1'b1;
    tick();

    // Single event: two-edge latency
    set_prio(3, 3'd2);
    pulse_pend(N_SRC'(1) << 3);
    chk("single_lat1", 32'(o_IRQ), 32'd0);
    tick();
    serve("single", 3, 2, 0);
    tick();
    chk("single_no_rereq", 32'(o_IRQ), 32'd0);

    // Tie and priority ordering
    set_prio(4, 3'd5);
    set_prio(9, 3'd5);
    set_prio(20, 3'd6);
    pulse_pend((N_SRC'(1) << 4) | (N_SRC'(1) << 9) | (N_SRC'(1) << 20));
    tick();
    serve("tie_20", 20, 6, 0);
    tick();
    serve("tie_4", 4, 5, 0);
    tick();
    serve("tie_9", 9, 5, 0);
    tick();
    chk("tie_done", 32'(o_IRQ), 32'd0);

`ifdef VIC_NEST_EN
    // Higher priority preempts the running level
    set_prio(2, 3'd1);
    set_prio(7, 3'd3);
    pulse_pend(N_SRC'(1) << 2);
    tick();
    chk("pre_addr2", 32'(o_irq_addr), 32'd2);
    do_ack();
    chk("pre_run1", 32'(o_run_prio), 32'd1);
    pulse_pend(N_SRC'(1) << 7);
    tick();
    serve("pre_7", 7, 3, 1);
    do_eoi();
    chk("pre_run0", 32'(o_run_prio), 32'd0);
`else
    // Without nesting a higher priority waits for EOI
    set_prio(2, 3'd1);
    set_prio(7, 3'd3);
    pulse_pend(N_SRC'(1) << 2);
    tick();
    chk("busy_addr2", 32'(o_irq_addr), 32'd2);
    do_ack();
    chk("busy_run1", 32'(o_run_prio), 32'd1);
    pulse_pend(N_SRC'(1) << 7);
    tick();
    chk("busy_blocked", 32'(o_IRQ), 32'd0);
    do_eoi();
    chk("busy_run0", 32'(o_run_prio), 32'd0);
    tick();
    serve("busy_7", 7, 3, 0);
`endif

    // Equal priority never preempts
    set_prio(1, 3'd3);
    pulse_pend(N_SRC'(1) << 7);
    tick();
    chk("eq_addr7", 32'(o_irq_addr), 32'd7);
    do_ack();
    chk("eq_run3", 32'(o_run_prio), 32'd3);
    pulse_pend(N_SRC'(1) << 1);
    tick();
    tick();
    chk("eq_blocked", 32'(o_IRQ), 32'd0);
    do_eoi();
    chk("eq_eoi_irq", 32'(o_IRQ), 32'd0);
    tick();
    serve("eq_1", 1, 3, 0);

    // Masked source is never requested
    set_prio(10, 3'd0);
    pulse_pend(N_SRC'(1) << 10);
    tick();
    tick();
    chk("mask_irq", 32'(o_IRQ), 32'd0);

    // Enable withdrawal keeps the pending bit
    set_prio(12, 3'd4);
    pulse_pend(N_SRC'(1) << 12);
    tick();
    chk("en_addr12", 32'(o_irq_addr), 32'd12);
    i_en = 1'b0;
    tick();
    chk("en_drop", 32'(o_IRQ), 32'd0);
    tick();
    chk("en_stay_low", 32'(o_IRQ), 32'd0);
    i_en = 1'b1;
    tick();
    serve("en_rereq", 12, 4, 0);

    // Ack and EOI on one edge with nothing in service: ack wins
    set_prio(5, 3'd2);
    pulse_pend(N_SRC'(1) << 5);
    tick();
    chk("ackeoi_addr", 32'(o_irq_addr), 32'd5);
    i_ack = 1'b1;
    i_eoi = 1'b1;
    tick();
    i_ack = 1'b0;
    i_eoi = 1'b0;
    chk("ackeoi_run", 32'(o_run_prio), 32'd2);
    do_eoi();
    chk("ackeoi_run0", 32'(o_run_prio), 32'd0);

    // Acknowledge outside a request is ignored
    do_ack();
    chk("idle_ack_run", 32'(o_run_prio), 32'd0);

    // Asynchronous reset mid-request
    pulse_pend(N_SRC'(1) << 12);
    tick();
    chk("arst_pre_irq", 32'(o_IRQ), 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_irq", 32'(o_IRQ), 32'd0);
    chk("arst_addr", 32'(o_irq_addr), 32'd0);
    chk("arst_run", 32'(o_run_prio), 32'd0);
    tick();
    i_rst_n = 1'b1;
    tick();
    tick();
    chk("arst_pend_lost", 32'(o_IRQ), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vic_nest_ctrl.md
# vic_nest_ctrl

Priority scheduler and nesting controller for the vectored interrupt controller. Takes the qualified per-source pending events from the VIC edge/level detection stage and selects the highest-priority source, or the lowest-numbered source on a tie. Drives a single IRQ request and vector to the CPU. Tracks in-service priority levels through an acknowledge/end-of-interrupt (EOI) handshake, so that only strictly higher-priority sources can preempt.

## Interface
- N_SRC, 31, number of interrupt sources
- AW, 5, vector width; 2^AW >= N_SRC
- PRIO_W, 3, per-source priority width; 0 = masked
- i_clk  in  1  system clock; all state changes on its rising edge
- i_rst_n  in  1  reset; asynchronous, active-low
- i_en  in  1  global enable
- i_pend  in  N_SRC  qualified event per source (pulse or level) from detection stage
- i_prio  in  N_SRC*PRIO_W  priority of source s at bits [s*PRIO_W +: PRIO_W]
- i_ack  in  1  CPU acknowledge pulse; takes the presented vector into service
- i_eoi  in  1  CPU end-of-interrupt pulse
- o_IRQ  out  1  interrupt request to CPU
- o_irq_addr  out  AW  vector of the requested source
- o_run_prio  out  PRIO_W  current running priority (0 = none in service)

## Operation
- pend[N_SRC-1:0] register:
  - bit s is set on any edge where i_pend[s]=1.
  - bit s is cleared only when source s is acknowledged.
  - Set wins over clear in the same edge.
- isr[2^PRIO_W-1:1] register: one bit per priority level in service.
  - run_prio is the index of the highest set isr bit, or 0 if none are set.
- Candidate: pending source with i_prio != 0 and i_prio > run_prio.
  - Maximum priority wins; a tie goes to the lowest index.
- FSM states IDLE and REQ.
  - IDLE → REQ: i_en=1 and a candidate exists. Register the candidate's vector and priority.
  - REQ, i_ack=1 → IDLE:
    - clear pend[vector];
    - set isr[latched priority];
    - drop o_IRQ.
  - REQ, i_en=0 → IDLE: request withdrawn; pend unchanged.
  - In REQ the vector is frozen. A newly arriving higher candidate does not retarget the request; it is requested after the ack.
- i_ack in IDLE is ignored.
- i_eoi clears the highest set isr bit. i_eoi with isr empty is ignored.
- i_ack and i_eoi on the same edge: the EOI clear is applied first, then the ack set.
- Priority changes on i_prio take effect on the next selection only; a latched request is unaffected.

## Timing
- Reset values:
  - o_IRQ=0, o_irq_addr=0, o_run_prio=0;
  - pend=0, isr=0;
  - FSM=IDLE.
- i_pend[s] high before edge k → pend set at edge k → REQ entered at edge k+1. o_IRQ and o_irq_addr are valid after edge k+1 (2-edge latency).
- o_IRQ, o_irq_addr and o_run_prio are registered outputs with no combinational paths from inputs.
- i_ack at edge j → o_IRQ=0 after edge j. The next request is asserted after edge j+1 at the earliest, so o_IRQ is low for at least one cycle between requests.
- i_eoi at edge j → o_run_prio is updated after edge j. A newly eligible candidate raises o_IRQ after edge j+1.
- Reset asserted mid-request: all state clears immediately (asynchronously); pending events are lost.

## Configuration
- VIC_NEST_EN defined: full nesting as above; up to 2^PRIO_W-1 levels in service.
- VIC_NEST_EN undefined:
  - isr collapses to a single busy bit;
  - the candidate condition requires isr empty (no preemption);
  - i_eoi clears the busy bit;
  - o_run_prio reports the priority of the source in service.

## Structure
- Shared package vic_pkg holds:
  - constants N_SRC, AW, PRIO_W;
  - FSM state encoding (IDLE, REQ).
  vic_irq and the VIC bench use the same package.
- One sub-module, vic_prio_sel: combinational priority/index resolver. It takes pend, i_prio and run_prio, and produces the candidate valid flag, vector and priority. The top level holds only the registers and the FSM.

## Test plan
- Single event: i_prio[3]=2, pulse i_pend[3] → o_IRQ=1 with o_irq_addr=3 two edges later. i_ack → o_IRQ=0, o_run_prio=2. i_eoi → o_run_prio=0.
- Tie/priority: sources 4 and 9 both at priority 5 and source 20 at priority 6, all pending together → vectors 20, then 4, then 9, each after ack+EOI.
- Preemption (VIC_NEST_EN): source 2 (prio 1) in service, then source 7 (prio 3) pends → o_IRQ, vector 7. After its ack o_run_prio=3; EOI → o_run_prio=1.
- No preemption of equal/lower priority: source 7 (prio 3) in service, source 1 (prio 3) pends → o_IRQ stays 0 until i_eoi, then vector 1.
- Masking/enable: i_prio=0 source pending → never requested. i_en dropped while in REQ → o_IRQ=0 next edge, pend retained; re-enabling re-requests the same vector.
- Async reset: assert i_rst_n=0 mid-REQ, off the clock edge → o_IRQ=0, o_irq_addr=0, o_run_prio=0 immediately.
